mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all widths come from the package types mem_in_type and mem_out_type.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_in  input  mem_in_type  fetch-side request; mem_valid is a one-cycle pulse.
REQ-006 imem_out  output  mem_out_type  fetch-side response (mem_rdata, mem_ready).
REQ-007 dmem_in  input  mem_in_type  data-side request from writebuffer; mem_valid is a one-cycle pulse; mem_fence is valid.
REQ-008 dmem_out  output  mem_out_type  data-side response.
REQ-009 mem_out  input  mem_out_type  shared memory response.
REQ-010 mem_in  output  mem_in_type  shared memory request.

Function
REQ-011 States SHALL be IDLE, BUSY_I and BUSY_D, plus one pending register per requester holding addr, wdata, wstrb, fence and a valid bit.
REQ-012 Requests SHALL be accepted in any state; an accepted request SHALL be stored in that requester's pending register unless it is granted in the same cycle.
REQ-013 In IDLE, a grant candidate SHALL be either a live request or a pending request; with one candidate, that candidate SHALL be granted combinationally in the same cycle (zero added latency).
REQ-014 With both candidates present, the winner SHALL be chosen by the policy in REQ-028; the loser SHALL remain or become pending.
REQ-015 On a grant, the FSM SHALL move to BUSY_I or BUSY_D and latch the granted fields.
REQ-016 mem_in SHALL carry the following and stay stable until mem_out.mem_ready=1 (inclusive):
- mem_valid=1 in BUSY.
- mem_instr=1 for BUSY_I and 0 for BUSY_D.
- mem_fence as latched; it is forced to 0 for BUSY_I.
REQ-017 In BUSY_x with mem_out.mem_ready=1, mem_rdata and mem_ready SHALL be routed to x_out in the same cycle, and the other port's mem_ready SHALL be 0.
REQ-018 After completion, the FSM SHALL return to IDLE; any pending request SHALL be granted in the next cycle, giving exactly one bubble cycle between transactions.
REQ-019 Each requester SHALL have at most one outstanding request; a new valid pulse from a requester whose request is pending or in flight SHALL be ignored.
REQ-020 mem_out.mem_ready while in IDLE SHALL be ignored and not forwarded.
REQ-021 imem_out and dmem_out rdata SHALL be 0 whenever their mem_ready is 0.
REQ-022 A request with wstrb=0 and fence=0 SHALL be a load; all other fields SHALL pass through unmodified.

Reset
REQ-023 On rst=1 at a clock edge: state SHALL be IDLE, both pending valid bits 0, latched fields 0, and last-grant register 0 (fetch).
REQ-024 While in reset state, all outputs SHALL be 0: mem_in.mem_valid, mem_in fields, both mem_ready, and both rdata.
REQ-025 Reset mid-transaction SHALL discard the in-flight and pending requests; a late mem_ready after reset SHALL be ignored per REQ-020.
REQ-026 A request pulse coinciding with rst=1 SHALL be dropped.

Configuration
REQ-027 Macro ARBITER_ROUND_ROBIN_EN.
REQ-028 Tie resolution:
- Defined: a tie SHALL grant the requester not granted last; the last-grant register updates on every grant.
- Undefined: data side SHALL always win ties; the last-grant register is absent.
REQ-029 Non-tie behaviour SHALL be identical in both builds.

Verification
REQ-030 Single load, idle: dmem_in valid, addr=0x100, wstrb=0 at cycle 0 -> mem_in.mem_valid=1, mem_instr=0 at cycle 0; mem_ready with rdata=0xDEADBEEF at cycle 3 -> dmem_out.mem_ready=1, rdata=0xDEADBEEF at cycle 3; imem_out.mem_ready=0 throughout.
REQ-031 Simultaneous requests at cycle 0 (imem 0x0, dmem store 0x200/0x12345678/wstrb=0xF), memory ready after 2 cycles:
- Fixed build: dmem serviced first, completes cycle 2; imem issued cycle 3, completes cycle 5.
- Round-robin build after reset: dmem serviced first, since last grant is fetch.
REQ-032 Round-robin fairness: both requesters re-request immediately after each completion for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-033 Fence: dmem_in fence=1 while BUSY_I -> mem_in.mem_fence stays 0 until imem completes; the fence issues the next cycle with mem_fence=1 and mem_instr=0.
REQ-034 Reset mid-operation: rst=1 in BUSY_D with imem pending, then memory ready one cycle later -> no mem_ready on either port, mem_in.mem_valid=0, and the imem request is not reissued.
REQ-035 Duplicate pulse: imem valid at cycles 0 and 1 with memory busy -> exactly one fetch transaction issued (the cycle-0 addr).

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared memory port
// Define ARBITER_ROUND_ROBIN_EN to alternate tie winners instead of data-first.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_fence;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  input  mem_out_type mem_out,
  output mem_in_type  mem_in
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state;
  req_t   cur, pend_i, pend_d;
  logic   pend_i_vld, pend_d_vld;
  req_t   live_i, live_d, sel_i, sel_d;
  logic   acc_i, acc_d, cand_i, cand_d, tie_to_i, grant_i, grant_d;
  logic   unused_instr;

  assign unused_instr = imem_in.mem_instr ^ dmem_in.mem_instr;

  assign live_i = '{fence: imem_in.mem_fence, addr: imem_in.mem_addr,
                    wdata: imem_in.mem_wdata, wstrb: imem_in.mem_wstrb};
  assign live_d = '{fence: dmem_in.mem_fence, addr: dmem_in.mem_addr,
                    wdata: dmem_in.mem_wdata, wstrb: dmem_in.mem_wstrb};

  // A requester with a request already pending or in flight ignores new pulses.
  assign acc_i = !rst && imem_in.mem_valid && !pend_i_vld && (state != BUSY_I);
  assign acc_d = !rst && dmem_in.mem_valid && !pend_d_vld && (state != BUSY_D);

  assign cand_i = !rst && (state == IDLE) && (pend_i_vld || acc_i);
  assign cand_d = !rst && (state == IDLE) && (pend_d_vld || acc_d);
  assign sel_i  = pend_i_vld ? pend_i : live_i;
  assign sel_d  = pend_d_vld ? pend_d : live_d;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_d;
  assign tie_to_i = last_d;
`else
  assign tie_to_i = 1'b0;
`endif

  assign grant_i = cand_i && (!cand_d || tie_to_i);
  assign grant_d = cand_d && !grant_i;

  function automatic mem_in_type issue(input req_t r, input logic instr);
    mem_in_type m;
    m.mem_valid = 1'b1;
    m.mem_instr = instr;
    m.mem_fence = r.fence & ~instr;
    m.mem_addr  = r.addr;
    m.mem_wdata = r.wdata;
    m.mem_wstrb = r.wstrb;
    return m;
  endfunction

  always_comb begin
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (grant_i)      mem_in = issue(sel_i, 1'b1);
          else if (grant_d) mem_in = issue(sel_d, 1'b0);
        end
        BUSY_I: begin
          mem_in = issue(cur, 1'b1);
          if (mem_out.mem_ready) imem_out = mem_out;
        end
        BUSY_D: begin
          mem_in = issue(cur, 1'b0);
          if (mem_out.mem_ready) dmem_out = mem_out;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      pend_i     <= '0;
      pend_d     <= '0;
      pend_i_vld <= 1'b0;
      pend_d_vld <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_d     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= BUSY_I;
            cur        <= sel_i;
            pend_i_vld <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_d     <= 1'b0;
`endif
          end else if (grant_d) begin
            state      <= BUSY_D;
            cur        <= sel_d;
            pend_d_vld <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_d     <= 1'b1;
`endif
          end
        end
        BUSY_I, BUSY_D: if (mem_out.mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Park accepted requests that lost (or arrived while busy).
      if (acc_i && !grant_i) begin
        pend_i_vld <= 1'b1;
        pend_i     <= live_i;
      end
      if (acc_d && !grant_d) begin
        pend_d_vld <= 1'b1;
        pend_d     <= live_d;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  mem_in_type  imem_in = '0;
  mem_in_type  dmem_in = '0;
  mem_in_type  mem_in;
  mem_out_type imem_out, dmem_out;
  mem_out_type mem_out = '0;
  mem_out_type man_out = '0;

  int checks = 0;
  int passed = 0;
  int lat = 2;
  int age = 0;
  int n_fetch = 0;
  bit model_en = 1'b1;

  mem_in_type  exp_i[$];
  mem_in_type  exp_d[$];
  logic [31:0] rsp_i[$];
  logic [31:0] rsp_d[$];
  logic        got_order[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .mem_out(mem_out), .mem_in(mem_in)
  );

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Memory responder: ready lat cycles after issue, unless manually overridden.
  always @(posedge clk) begin
    #2;
    if (!model_en) begin
      mem_out = man_out;
      age = 0;
    end else if (rst || !mem_in.mem_valid) begin
      mem_out = '0;
      age = 0;
    end else if (age >= lat) begin
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata = rdata_of(mem_in.mem_addr);
      age = 0;
    end else begin
      mem_out = '0;
      age++;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && mem_in.mem_valid && mem_out.mem_ready) begin
      got_order.push_back(mem_in.mem_instr);
      if (mem_in.mem_instr) begin
        n_fetch++;
        check("txn_i_expected", 128'(exp_i.size() > 0), 128'(1));
        if (exp_i.size() > 0) check("txn_i", 128'(mem_in), 128'(exp_i.pop_front()));
      end else begin
        check("txn_d_expected", 128'(exp_d.size() > 0), 128'(1));
        if (exp_d.size() > 0) check("txn_d", 128'(mem_in), 128'(exp_d.pop_front()));
      end
    end
    if (imem_out.mem_ready) begin
      check("rsp_i_expected", 128'(rsp_i.size() > 0), 128'(1));
      if (rsp_i.size() > 0) check("rsp_i", 128'(imem_out.mem_rdata), 128'(rsp_i.pop_front()));
    end else begin
      check("rdata_i_zero", 128'(imem_out.mem_rdata), 128'(0));
    end
    if (dmem_out.mem_ready) begin
      check("rsp_d_expected", 128'(rsp_d.size() > 0), 128'(1));
      if (rsp_d.size() > 0) check("rsp_d", 128'(dmem_out.mem_rdata), 128'(rsp_d.pop_front()));
    end else begin
      check("rdata_d_zero", 128'(dmem_out.mem_rdata), 128'(0));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
  endtask

  task automatic pulse_i(input logic [31:0] addr, input bit push);
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_fence: 1'b0,
                mem_addr: addr, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    if (push) begin
      exp_i.push_back('{mem_valid: 1'b1, mem_instr: 1'b1, mem_fence: 1'b0,
                        mem_addr: addr, mem_wdata: 32'h0, mem_wstrb: 4'h0});
      rsp_i.push_back(rdata_of(addr));
    end
  endtask

  task automatic pulse_d(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic fence, input bit push);
    dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_fence: fence,
                mem_addr: addr, mem_wdata: wdata, mem_wstrb: wstrb};
    if (push) begin
      exp_d.push_back('{mem_valid: 1'b1, mem_instr: 1'b0, mem_fence: fence,
                        mem_addr: addr, mem_wdata: wdata, mem_wstrb: wstrb});
      rsp_d.push_back(rdata_of(addr));
    end
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int  rem_i, rem_d, fetch0;
    bit  out_i, out_d;
    logic exp_order [6];
`ifdef ARBITER_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

    // Reset state: all outputs zero, both during and right after reset
    next_cycle();
    @(negedge clk);
    check("rst_mem_in", 128'(mem_in), 128'(0));
    check("rst_imem_out", 128'(imem_out), 128'(0));
    check("rst_dmem_out", 128'(dmem_out), 128'(0));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("idle_mem_in", 128'(mem_in), 128'(0));

    // Single load from idle, zero-latency issue, ready at cycle 3
    lat = 3;
    next_cycle();
    pulse_d(32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("load_valid_c0", 128'(mem_in.mem_valid), 128'(1));
    check("load_instr_c0", 128'(mem_in.mem_instr), 128'(0));
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      @(negedge clk);
      check("load_dready", 128'(dmem_out.mem_ready), 128'(k == 3));
      check("load_iready", 128'(imem_out.mem_ready), 128'(0));
      if (k == 3) check("load_rdata", 128'(dmem_out.mem_rdata), 128'(32'hDEADBEEF));
    end
    next_cycle();
    @(negedge clk);
    check("load_after_idle", 128'(mem_in.mem_valid), 128'(0));

    // Simultaneous requests: data wins first tie after reset in both builds
    do_reset();
    lat = 2;
    next_cycle();
    pulse_i(32'h0, 1'b1);
    pulse_d(32'h200, 32'h12345678, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    check("tie_instr_c0", 128'(mem_in.mem_instr), 128'(0));
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      @(negedge clk);
      check("tie_dready", 128'(dmem_out.mem_ready), 128'(k == 2));
      check("tie_iready", 128'(imem_out.mem_ready), 128'(k == 5));
      if (k == 3) check("tie_i_issue", 128'({mem_in.mem_valid, mem_in.mem_instr}), 128'(2'b11));
    end

    // Fairness: both re-request right after each completion
    do_reset();
    lat = 1;
    got_order.delete();
    rem_i = 3; rem_d = 3; out_i = 0; out_d = 0;
    for (int c = 0; c < 60 && (rem_i > 0 || rem_d > 0 || out_i || out_d); c++) begin
      next_cycle();
      if (!out_i && rem_i > 0) begin
        pulse_i(32'h1000 + 32'(rem_i * 16), 1'b1);
        out_i = 1; rem_i--;
      end
      if (!out_d && rem_d > 0) begin
        pulse_d(32'h2000 + 32'(rem_d * 16), 32'(rem_d), 4'h3, 1'b0, 1'b1);
        out_d = 1; rem_d--;
      end
      @(negedge clk);
      if (imem_out.mem_ready) out_i = 0;
      if (dmem_out.mem_ready) out_d = 0;
    end
    check("fair_done", 128'({out_i, out_d, rem_i == 0, rem_d == 0}), 128'(4'b0011));
    next_cycle();
    @(negedge clk);
    check("fair_count", 128'(got_order.size()), 128'(6));
    for (int k = 0; k < 6; k++)
      if (k < got_order.size()) check("fair_order", 128'(got_order[k]), 128'(exp_order[k]));

    // Fence behind an in-flight fetch
    lat = 2;
    next_cycle();
    pulse_i(32'h300, 1'b1);
    @(negedge clk);
    check("fence_c0", 128'({mem_in.mem_fence, mem_in.mem_instr}), 128'(2'b01));
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 1) pulse_d(32'h400, 32'h0, 4'h0, 1'b1, 1'b1);
      @(negedge clk);
      if (k <= 2) check("fence_held", 128'({mem_in.mem_fence, mem_in.mem_instr}), 128'(2'b01));
      if (k == 3) check("fence_issue", 128'({mem_in.mem_valid, mem_in.mem_fence, mem_in.mem_instr}),
                        128'(3'b110));
      if (k == 5) check("fence_done", 128'(dmem_out.mem_ready), 128'(1));
    end

    // Reset while data busy and fetch pending; late ready must be dropped
    model_en = 1'b0;
    man_out = '0;
    next_cycle();
    pulse_d(32'h500, 32'h0, 4'h0, 1'b0, 1'b0);
    next_cycle();
    pulse_i(32'h600, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_in", 128'(mem_in), 128'(0));
    next_cycle();
    rst = 1'b0;
    man_out = '{mem_ready: 1'b1, mem_rdata: 32'hCAFEF00D};
    @(negedge clk);
    check("late_iready", 128'(imem_out.mem_ready), 128'(0));
    check("late_dready", 128'(dmem_out.mem_ready), 128'(0));
    check("late_valid", 128'(mem_in.mem_valid), 128'(0));
    next_cycle();
    man_out = '0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      check("no_reissue", 128'(mem_in.mem_valid), 128'(0));
    end
    model_en = 1'b1;

    // Duplicate fetch pulse while memory busy
    lat = 2;
    fetch0 = n_fetch;
    next_cycle();
    pulse_d(32'h700, 32'h0000A5A5, 4'h3, 1'b0, 1'b1);
    next_cycle();
    pulse_i(32'h800, 1'b1);
    next_cycle();
    pulse_i(32'h900, 1'b0);
    for (int k = 0; k < 8; k++) next_cycle();
    @(negedge clk);
    check("dup_fetch_count", 128'(n_fetch - fetch0), 128'(1));

    check("exp_i_empty", 128'(exp_i.size()), 128'(0));
    check("exp_d_empty", 128'(exp_d.size()), 128'(0));
    check("rsp_i_empty", 128'(rsp_i.size()), 128'(0));
    check("rsp_d_empty", 128'(rsp_d.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
